// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller, up to 8 request sources.
// Registers: 0 STATUS (W1C), 1 MASK, 2 MODE (1=edge, 0=level), 3 VECTOR (RO).
// Optional macro IRQ_CTRL_SYNC_EN adds a two-flop synchronizer ahead of src_q
// for sources that are asynchronous to clk.
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      addr,
  input  logic [7:0]      dbw,
  input  logic            we,
  output logic [7:0]      dbr,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  // Bits at or above NSRC are never stored and always read back as 0.
  localparam logic [7:0] VMASK = 8'((9'd1 << NSRC) - 9'd1);

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_MASK   = 2'd1;
  localparam logic [1:0] A_MODE   = 2'd2;
  localparam logic [1:0] A_VECTOR = 2'd3;

  logic [7:0] src_ext;   // requests widened to the 8-bit register width
  logic [7:0] smp;       // sample that loads src_q this clock
  logic [7:0] src_q;     // previous sample, for rising-edge detect
  logic [7:0] rise;
  logic [7:0] pend, pend_nxt;
  logic [7:0] mask, mode;
  logic [7:0] act;
  logic [7:0] vec;
  logic [7:0] rd_mux;
  logic       wr_sts, wr_mask, wr_mode;

  // Zero-extend the request vector to register width.
  always_comb begin
    src_ext           = '0;
    src_ext[NSRC-1:0] = src;
  end

`ifdef IRQ_CTRL_SYNC_EN
  logic [7:0] sync1, sync2;

  // Two-flop synchronizer for asynchronous request lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_ext;
      sync2 <= sync1;
    end
  end

  assign smp = sync2;
`else
  assign smp = src_ext;
`endif

  assign rise    = smp & ~src_q;
  assign act     = pend & mask;
  assign wr_sts  = we && (addr == A_STATUS);
  assign wr_mask = we && (addr == A_MASK);
  assign wr_mode = we && (addr == A_MODE);

  // Pending update: a MODE change clears the bit, edge bits set on rise and
  // clear on W1C (rise wins), level bits follow the same sample as src_q so
  // both modes reach irq two edges after the request rises.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      if (wr_mode && (dbw[i] != mode[i]))
        pend_nxt[i] = 1'b0;
      else if (mode[i])
        pend_nxt[i] = rise[i] | (pend[i] & ~(wr_sts & dbw[i]));
      else
        pend_nxt[i] = smp[i];
    end
    pend_nxt = pend_nxt & VMASK;
  end

  // Lowest active index wins; 8'h80 flags "nothing active".
  always_comb begin
    vec = 8'h80;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) vec = 8'(i);
    end
  end

  // Read mux over pre-write state; reads have no side effects.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_STATUS: rd_mux = pend;
      A_MASK:   rd_mux = mask;
      A_MODE:   rd_mux = mode;
      A_VECTOR: rd_mux = vec;
      default:  rd_mux = '0;
    endcase
  end

  // Request sampling and pending latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      pend  <= '0;
    end else begin
      src_q <= smp;
      pend  <= pend_nxt;
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      mode <= '0;
    end else begin
      if (wr_mask) mask <= dbw & VMASK;
      if (wr_mode) mode <= dbw & VMASK;
    end
  end

  // Registered outputs: irq follows act one clock later, dbr follows addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
      dbr <= 8'h00;
    end else begin
      irq <= |act;
      dbr <= rd_mux;
    end
  end

endmodule
